data_in_ctrl: RTL and testbench

//  Sequences the input-feature fetch for a 3x3, stride-1, pad-1 convolution. It

---
 rtl/data_in_ctrl.sv | 178 +++++++++++++++++
 tb/tb_data_in_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_in_ctrl
// Purpose  : Fetch sequencer for a 3x3, stride-1, pad-1 convolution. It walks
//            every output pixel's nine taps, issues input-SRAM reads for taps
//            that land inside the image, and tells data_in, one cycle later,
//            whether the tap is a real pixel or which kind of zero pad it is.
// Ports    :
//   clk           clock
//   rst           asynchronous reset, active-low
//   start         one-cycle pulse that begins a layer (accepted in IDLE only)
//   img_w/img_h   image width/height in pixels, sampled on start
//   base_addr     word address of pixel (0,0), sampled on start
//   stall         back-pressure; while high in RUN no tap is issued
//   Min_CS/Min_A  input-memory read enable / address (issue stage)
//   padding_type  11 real, 00 row pad, 01 col pad, 10 corner pad (stage 1)
//   tap_valid     padding_type carries a tap this cycle (stage 1)
//   win_last      with tap_valid: ninth tap (ky=2,kx=2) of a window
//   busy          high from start until done
//   done          one-cycle pulse at the end of a layer
// Revision : 1.0 - initial release
// ============================================================================
module data_in_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic              Min_CS,
    output logic [ADDR_W-1:0] Min_A,
    output logic [1:0]        padding_type,
    output logic              tap_valid,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]  width, height;
    logic [DIM_W-1:0]  oy, ox;
    logic [1:0]        ky, kx;
    // Address of column 0 of input row iy = oy+ky-1 (wraps when iy = -1).
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_hold;

    logic              issue;
    logic              row_miss, col_miss, in_range;
    logic              last_tap;
    logic [DIM_W-1:0]  w_last, h_last;
    logic [ADDR_W-1:0] tap_addr;
    logic [1:0]        pt_now;

    assign w_last   = width  - DIM_W'(1);
    assign h_last   = height - DIM_W'(1);
    assign issue    = (state == S_RUN) && !stall;

    // With stride 1 / pad 1 the tap can only leave the image on the outer
    // kernel row/column of an edge output pixel.
    assign row_miss = ((ky == 2'd0) && (oy == '0)) || ((ky == 2'd2) && (oy == h_last));
    assign col_miss = ((kx == 2'd0) && (ox == '0)) || ((kx == 2'd2) && (ox == w_last));
    assign in_range = !row_miss && !col_miss;

    assign tap_addr = row_base + ADDR_W'(ox) + ADDR_W'(kx) - ADDR_W'(1);
    assign last_tap = (ky == 2'd2) && (kx == 2'd2) && (ox == w_last) && (oy == h_last);

    assign Min_CS   = issue && in_range;
    assign Min_A    = Min_CS ? tap_addr : addr_hold;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        pt_now = 2'b11;
        if (row_miss && col_miss)
            pt_now = 2'b10;
        else if (row_miss)
            pt_now = 2'b00;
        else if (col_miss)
            pt_now = 2'b01;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = ((img_w == '0) || (img_h == '0)) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (issue && last_tap)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Tap counters and incremental row base.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width     <= '0;
            height    <= '0;
            oy        <= '0;
            ox        <= '0;
            ky        <= '0;
            kx        <= '0;
            row_base  <= '0;
            addr_hold <= '0;
        end else if ((state == S_IDLE) && start) begin
            width    <= img_w;
            height   <= img_h;
            oy       <= '0;
            ox       <= '0;
            ky       <= '0;
            kx       <= '0;
            row_base <= base_addr - ADDR_W'(img_w);
        end else if (issue) begin
            if (Min_CS)
                addr_hold <= tap_addr;
            if (kx != 2'd2) begin
                kx <= kx + 2'd1;
            end else begin
                kx <= 2'd0;
                if (ky != 2'd2) begin
                    ky       <= ky + 2'd1;
                    row_base <= row_base + ADDR_W'(width);
                end else begin
                    ky <= 2'd0;
                    if (ox != w_last) begin
                        // Same output row: step back from iy=oy+1 to iy=oy-1.
                        ox       <= ox + DIM_W'(1);
                        row_base <= row_base - ADDR_W'({width, 1'b0});
                    end else if (oy != h_last) begin
                        // Next output row: iy=oy+1 becomes the new iy=(oy+1)-1.
                        ox       <= '0;
                        oy       <= oy + DIM_W'(1);
                        row_base <= row_base - ADDR_W'(width);
                    end
                end
            end
        end
    end

    // Stage 1: aligned with the SRAM read data of the issued tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_valid    <= 1'b0;
            padding_type <= 2'b00;
            win_last     <= 1'b0;
        end else begin
            tap_valid    <= issue;
            padding_type <= issue ? pt_now : 2'b00;
            win_last     <= issue && (ky == 2'd2) && (kx == 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_in_ctrl
// Purpose  : Directed self-checking bench for data_in_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_in_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  img_w = '0;
    logic [7:0]  img_h = '0;
    logic [15:0] base_addr = '0;
    logic        Min_CS;
    logic [15:0] Min_A;
    logic [1:0]  padding_type;
    logic        tap_valid, win_last, busy, done;

    data_in_ctrl #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .base_addr(base_addr), .stall(stall), .Min_CS(Min_CS), .Min_A(Min_A),
        .padding_type(padding_type), .tap_valid(tap_valid), .win_last(win_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int n_tap, n_wl, n_done, n_busy, n_cs, n_bad;
    int done_t, last_tap_t, start_cyc;
    logic [1:0]  pt_q[$];
    logic [15:0] addr_q[$];
    logic [1:0]  exp_pt[$];
    logic [15:0] exp_addr[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tap_valid) begin
            n_tap++;
            pt_q.push_back(padding_type);
            last_tap_t = cyc;
            if (win_last) n_wl++;
        end else if (padding_type != 2'b00 || win_last) begin
            n_bad++;
        end
        if (Min_CS) begin
            n_cs++;
            addr_q.push_back(Min_A);
            if (stall) n_bad++;
        end
        if (busy) n_busy++;
        if (done) begin
            n_done++;
            done_t = cyc;
        end
    end

    task automatic clear_mon();
        n_tap = 0; n_wl = 0; n_done = 0; n_busy = 0; n_cs = 0; n_bad = 0;
        done_t = 0; last_tap_t = 0;
        pt_q.delete();
        addr_q.delete();
    endtask

    // Independent reference: direct iy*W+ix addressing.
    task automatic build_model(input int w, input int h, input int base);
        exp_pt.delete();
        exp_addr.delete();
        for (int oy = 0; oy < h; oy++)
            for (int ox = 0; ox < w; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        int iy, ix;
                        logic rm, cm;
                        iy = oy + ky - 1;
                        ix = ox + kx - 1;
                        rm = (iy < 0) || (iy >= h);
                        cm = (ix < 0) || (ix >= w);
                        if (rm && cm)   exp_pt.push_back(2'b10);
                        else if (rm)    exp_pt.push_back(2'b00);
                        else if (cm)    exp_pt.push_back(2'b01);
                        else begin
                            exp_pt.push_back(2'b11);
                            exp_addr.push_back(16'((base + iy * w + ix) & 32'hFFFF));
                        end
                    end
    endtask

    task automatic compare_model(input string tag);
        int mis;
        check({tag, "_pt_len"}, pt_q.size(), exp_pt.size());
        check({tag, "_rd_len"}, addr_q.size(), exp_addr.size());
        mis = 0;
        for (int i = 0; i < pt_q.size() && i < exp_pt.size(); i++)
            if (pt_q[i] !== exp_pt[i]) mis++;
        check({tag, "_pt_seq_mismatches"}, mis, 0);
        mis = 0;
        for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
            if (addr_q[i] !== exp_addr[i]) mis++;
        check({tag, "_addr_seq_mismatches"}, mis, 0);
        check({tag, "_bad_cycles"}, n_bad, 0);
    endtask

    task automatic start_layer(input int w, input int h, input int base);
        @(negedge clk);
        clear_mon();
        img_w = 8'(w);
        img_h = 8'(h);
        base_addr = 16'(base);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done_seen"}, n_done, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    logic [1:0] pt1[9];

    initial begin
        pt1 = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
        clear_mon();

        // Reset state
        #12;
        check("rst_outputs", {Min_CS, Min_A, padding_type, tap_valid, win_last, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1. 1x1 image
        start_layer(1, 1, 16'h100);
        wait_done("t1");
        check("t1_taps", n_tap, 9);
        check("t1_reads", n_cs, 1);
        check("t1_addr", addr_q.size() > 0 ? addr_q[0] : 16'hDEAD, 16'h100);
        for (int i = 0; i < 9; i++)
            check($sformatf("t1_pt%0d", i), i < pt_q.size() ? pt_q[i] : 2'bxx, pt1[i]);
        check("t1_win_last", n_wl, 1);
        check("t1_done_after_tap", done_t - last_tap_t, 1);
        check("t1_duration", done_t - start_cyc, 11);
        check("t1_busy_cycles", n_busy, 11);

        // 2. 3x3 image, with a start pulse during busy that must be ignored
        start_layer(3, 3, 0);
        repeat (20) @(negedge clk);
        img_w = 8'd1;
        img_h = 8'd1;
        base_addr = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2");
        check("t2_taps", n_tap, 81);
        check("t2_win_last", n_wl, 9);
        check("t2_reads", n_cs, 49);
        for (int i = 0; i < 9; i++)
            check($sformatf("t2_centre_addr%0d", i),
                  (20 + i) < addr_q.size() ? addr_q[20 + i] : 16'hDEAD, 16'(i));
        check("t2_done_after_tap", done_t - last_tap_t, 1);
        check("t2_duration", done_t - start_cyc, 83);
        build_model(3, 3, 0);
        compare_model("t2");

        // 3. 4x2 image with a 3-cycle stall mid-window
        start_layer(4, 2, 16'h40);
        repeat (11) @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_done("t3");
        check("t3_taps", n_tap, 72);
        check("t3_win_last", n_wl, 8);
        check("t3_reads", n_cs, 40);
        check("t3_duration", done_t - start_cyc, 77);
        build_model(4, 2, 16'h40);
        compare_model("t3");

        // 4. Address wrap
        start_layer(2, 2, 16'hFFFE);
        wait_done("t4");
        check("t4_a0", addr_q.size() > 3 ? addr_q[0] : 16'hDEAD, 16'hFFFE);
        check("t4_a1", addr_q.size() > 3 ? addr_q[1] : 16'hDEAD, 16'hFFFF);
        check("t4_a2", addr_q.size() > 3 ? addr_q[2] : 16'hDEAD, 16'h0000);
        check("t4_a3", addr_q.size() > 3 ? addr_q[3] : 16'hDEAD, 16'h0001);
        build_model(2, 2, 16'hFFFE);
        compare_model("t4");

        // 5. Zero width; start held into the busy cycle
        @(negedge clk);
        clear_mon();
        img_w = 8'd0;
        img_h = 8'd5;
        base_addr = 16'h0;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("t5_reads", n_cs, 0);
        check("t5_taps", n_tap, 0);
        check("t5_busy_cycles", n_busy, 1);
        check("t5_done_count", n_done, 1);
        check("t5_duration", done_t - start_cyc, 1);

        // 6. Reset mid-RUN, then a fresh layer
        start_layer(3, 3, 0);
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_outputs", {Min_CS, Min_A, padding_type, tap_valid, win_last, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_done", n_done, 0);
        start_layer(2, 2, 16'h10);
        wait_done("t6");
        check("t6_taps", n_tap, 36);
        check("t6_win_last", n_wl, 4);
        build_model(2, 2, 16'h10);
        compare_model("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
